// File: rtl/memory_pkg.sv
// Shared encodings for the memory responder: access sizes,
// MMIO offsets, FSM states and per-size helpers.
package memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam logic [1:0] MMIO_PASS  = 2'd0;
  localparam logic [1:0] MMIO_FAIL  = 2'd1;
  localparam logic [1:0] MMIO_DEBUG = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        write;
  } req_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    unique case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] size_be(input logic [1:0] size);
    unique case (size)
      SIZE_BYTE: return 4'b0001;
      SIZE_HALF: return 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    unique case (size)
      SIZE_BYTE: return 32'h0000_00ff;
      SIZE_HALF: return 32'h0000_ffff;
      SIZE_WORD: return 32'hffff_ffff;
      default:   return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/memory_responder_byte_ram.sv
// Four byte-wide banks with a registered read port; lanes are
// rotated so unaligned accesses reach the right bank and word.
module byte_ram #(
  parameter int unsigned RAM_BYTES = 65536,
  parameter string       INIT_FILE = "",
  parameter int          AW        = $clog2(RAM_BYTES)
) (
  input  logic          clock,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = RAM_BYTES / 4;
  localparam int WA    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WA-1:0]   word;
  logic [1:0]      off;
  logic [1:0]      off_q;
  logic [3:0][7:0] q;

  assign word = WA'({1'b0, addr} >> 2);
  assign off  = addr[1:0];

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0]    mem [1 << WA];
    logic [1:0]    k;
    logic [WA-1:0] idx;
    logic [7:0]    q_b;

    assign k   = 2'(b) - off;
    assign idx = word + WA'((2'(b) < off) ? 1 : 0);

    always @(posedge clock) begin
      if (we && be[k]) mem[idx] <= wdata[8*k +: 8];
      if (re) q_b <= mem[idx];
    end

    assign q[b] = q_b;
  end

  always @(posedge clock) begin
    if (re) off_q <= off;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) rdata[8*i +: 8] = q[2'(i) + off_q];
  end

endmodule

// File: rtl/memory_responder.sv
// Enable/ready memory target: RAM, pass/fail/debug MMIO and a
// programmable wait-state counter.
module memory_responder
  import memory_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 65536,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] MMIO_BASE = 32'hFFFFFD,
  parameter string       INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_data_out,
  input  logic [1:0]  memory_data_size,
  input  logic        memory_enable,
  input  logic        memory_operation,
  output logic [31:0] memory_data_in,
  output logic        memory_ready,
  output logic        test_done,
  output logic        test_pass,
  output logic [7:0]  test_code,
  output logic        debug_valid,
  output logic [7:0]  debug_data,
  output logic        access_fault
);

  localparam int AW = $clog2(RAM_BYTES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  req_t        req;
  logic [31:0] rmask;
  logic [31:0] ram_rdata;
  logic [32:0] end_addr;
  logic [31:0] moff;
  logic        rsvd;
  logic        in_ram;
  logic        is_mmio;
  logic        straddle;
  logic        commit;

  always_comb begin
    end_addr = {1'b0, req.addr} + {30'd0, size_bytes(req.size)};
    moff     = req.addr - MMIO_BASE;
    rsvd     = req.size == SIZE_RSVD;
    in_ram   = !rsvd && end_addr <= 33'(RAM_BYTES);
    is_mmio  = !rsvd && !in_ram && req.addr >= MMIO_BASE && moff < 32'd3;
    straddle = !rsvd && !in_ram && req.addr < RAM_BYTES;
  end

  // RAM strobes are combinational so a reset clears them instantly
  assign commit = state == ST_WAIT && memory_enable && cnt == 4'd0;

  byte_ram #(
    .RAM_BYTES(RAM_BYTES),
    .INIT_FILE(INIT_FILE),
    .AW       (AW)
  ) u_ram (
    .clock(clock),
    .we   (commit && req.write && in_ram),
    .re   (commit && !req.write && in_ram),
    .addr (req.addr[AW-1:0]),
    .be   (size_be(req.size)),
    .wdata(req.wdata),
    .rdata(ram_rdata)
  );

  assign memory_data_in = ram_rdata & rmask;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      req          <= '0;
      rmask        <= '0;
      memory_ready <= 1'b0;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_code    <= '0;
      debug_valid  <= 1'b0;
      debug_data   <= '0;
      access_fault <= 1'b0;
    end else begin
      debug_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (memory_enable) begin
            req.addr  <= memory_address;
            req.wdata <= memory_data_out;
            req.size  <= memory_data_size;
            req.write <= memory_operation;
            cnt       <= 4'(LATENCY);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!memory_enable) begin
            access_fault <= 1'b1;
            state        <= ST_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            memory_ready <= 1'b1;
            state        <= ST_READY;
            rmask        <= (!req.write && in_ram) ? size_mask(req.size) : '0;
            if (rsvd || straddle) access_fault <= 1'b1;
            if (req.write && is_mmio) begin
              unique case (moff[1:0])
                MMIO_PASS, MMIO_FAIL: begin
                  if (!test_done) begin
                    test_done <= 1'b1;
                    test_pass <= moff[1:0] == MMIO_PASS;
                    test_code <= req.wdata[7:0];
                  end
                end
                MMIO_DEBUG: begin
                  debug_data  <= req.wdata[7:0];
                  debug_valid <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        ST_READY: begin
          if (!memory_enable) begin
            memory_ready <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Randomised scoreboard bench for memory_responder against a
// byte-array reference model.
module tb_memory_responder;

  localparam int          LAT  = 2;
  localparam int          RAM  = 65536;
  localparam logic [31:0] MMIO = 32'hFFFFFD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memory_address = '0;
  logic [31:0] memory_data_out = '0;
  logic [1:0]  memory_data_size = '0;
  logic        memory_enable = 1'b0;
  logic        memory_operation = 1'b0;
  logic [31:0] memory_data_in;
  logic        memory_ready;
  logic        test_done;
  logic        test_pass;
  logic [7:0]  test_code;
  logic        debug_valid;
  logic [7:0]  debug_data;
  logic        access_fault;

  memory_responder #(
    .RAM_BYTES(RAM),
    .LATENCY  (LAT),
    .MMIO_BASE(MMIO),
    .INIT_FILE("")
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .memory_address  (memory_address),
    .memory_data_out (memory_data_out),
    .memory_data_size(memory_data_size),
    .memory_enable   (memory_enable),
    .memory_operation(memory_operation),
    .memory_data_in  (memory_data_in),
    .memory_ready    (memory_ready),
    .test_done       (test_done),
    .test_pass       (test_pass),
    .test_code       (test_code),
    .debug_valid     (debug_valid),
    .debug_data      (debug_data),
    .access_fault    (access_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          chk;
    logic [31:0] d;
  } exp_t;

  exp_t       exp_q[$];
  bit [7:0]   mem_m [RAM];
  bit         exp_fault;
  bit         exp_done;
  bit         exp_pass;
  bit [7:0]   exp_code;
  bit [7:0]   exp_dbg;
  int         exp_dbg_n;
  int         dbg_n;
  int         errors;
  int         checks;
  logic       prev_ready;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: classify by address/size, then act on a byte array
  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [1:0] s,
                                        input bit wr,
                                        input logic [31:0] d);
    logic [31:0] r;
    int          n;
    r = '0;
    if (s == 2'd3) begin
      exp_fault = 1'b1;
      return '0;
    end
    n = 1 << s;
    if (64'(a) + 64'(n) <= 64'(RAM)) begin
      for (int i = 0; i < n; i++) begin
        if (wr) mem_m[a+i] = d[8*i +: 8];
        else r[8*i +: 8] = mem_m[a+i];
      end
      return r;
    end
    if (a >= MMIO && a - MMIO < 3) begin
      if (wr) begin
        if (a - MMIO < 2) begin
          if (!exp_done) begin
            exp_done = 1'b1;
            exp_pass = (a == MMIO);
            exp_code = d[7:0];
          end
        end else begin
          exp_dbg = d[7:0];
          exp_dbg_n++;
        end
      end
      return '0;
    end
    if (a < RAM) exp_fault = 1'b1;
    return '0;
  endfunction

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (memory_ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready with empty scoreboard");
      end else begin
        e = exp_q.pop_front();
        if (e.chk) check("rdata", memory_data_in, e.d);
      end
    end
    prev_ready = memory_ready;
    if (debug_valid) dbg_n++;
  end

  task automatic access(input logic [31:0] a, input logic [1:0] s,
                        input bit wr, input logic [31:0] d);
    exp_t e;
    int   n;
    e.d   = model(a, s, wr, d);
    e.chk = !wr;
    exp_q.push_back(e);
    @(negedge clock);
    memory_address   = a;
    memory_data_size = s;
    memory_operation = wr;
    memory_data_out  = d;
    memory_enable    = 1'b1;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!memory_ready && n < 20);
    check("ready_latency", 32'(n - 1), 32'(LAT + 1));
    if (!memory_ready) exp_q.delete();
    memory_enable = 1'b0;
    @(posedge clock);
    #1;
    check("ready_fall", 32'(memory_ready), 32'd0);
    check("fault", 32'(access_fault), 32'(exp_fault));
  endtask

  task automatic check_mmio();
    check("test_done", 32'(test_done), 32'(exp_done));
    check("test_pass", 32'(test_pass), 32'(exp_pass));
    check("test_code", 32'(test_code), 32'(exp_code));
    check("debug_data", 32'(debug_data), 32'(exp_dbg));
    check("debug_pulses", 32'(dbg_n), 32'(exp_dbg_n));
  endtask

  task automatic model_reset();
    exp_fault = 1'b0;
    exp_done  = 1'b0;
    exp_pass  = 1'b0;
    exp_code  = '0;
    exp_dbg   = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    model_reset();
    exp_dbg_n  = 0;
    dbg_n      = 0;
    errors     = 0;
    checks     = 0;
    prev_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(memory_ready), 32'd0);
    check("rst_rdata", memory_data_in, 32'd0);
    check("rst_fault", 32'(access_fault), 32'd0);
    check("rst_dvalid", 32'(debug_valid), 32'd0);
    check_mmio();
    @(negedge clock);
    reset = 1'b1;

    access(32'h100, 2'd2, 1'b1, 32'hDEADBEEF);
    access(32'h101, 2'd0, 1'b0, 32'h0);
    access(32'h102, 2'd1, 1'b0, 32'h0);
    access(32'h0FF, 2'd2, 1'b0, 32'h0);

    access(MMIO, 2'd0, 1'b1, 32'h07);
    access(MMIO + 1, 2'd0, 1'b1, 32'h09);
    access(MMIO, 2'd0, 1'b0, 32'h0);
    check_mmio();

    for (int i = 1; i <= 3; i++) access(MMIO + 2, 2'd0, 1'b1, 32'(i));
    check_mmio();
    access(32'h100, 2'd2, 1'b0, 32'h0);

    for (int i = 0; i < 64; i++)
      access(32'h100 + 32'(4*i), 2'd2, 1'b1, $urandom);
    for (int i = 0; i < 80; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 32'hFC));
      access(a, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             $urandom);
      if ($urandom_range(0, 9) == 0)
        access(MMIO + 2, 2'd0, 1'b1, $urandom);
    end
    check_mmio();

    access(32'(RAM - 4), 2'd2, 1'b1, 32'hCAFEF00D);
    access(32'(RAM - 4), 2'd2, 1'b0, 32'h0);
    access(32'(RAM), 2'd0, 1'b0, 32'h0);
    access(32'(RAM), 2'd2, 1'b1, 32'h12345678);

    access(32'h200, 2'd0, 1'b1, 32'hAA);
    @(negedge clock);
    memory_address   = 32'h200;
    memory_data_size = 2'd0;
    memory_operation = 1'b1;
    memory_data_out  = 32'h55;
    memory_enable    = 1'b1;
    @(negedge clock);
    memory_enable = 1'b0;
    exp_fault     = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("abort_ready", 32'(memory_ready), 32'd0);
    check("abort_fault", 32'(access_fault), 32'd1);
    access(32'h200, 2'd0, 1'b0, 32'h0);

    @(negedge clock);
    memory_address   = 32'h200;
    memory_data_size = 2'd0;
    memory_operation = 1'b1;
    memory_data_out  = 32'h66;
    memory_enable    = 1'b1;
    @(posedge clock);
    #2;
    reset         = 1'b0;
    memory_enable = 1'b0;
    model_reset();
    #1;
    check("rst_mid_ready", 32'(memory_ready), 32'd0);
    check("rst_mid_fault", 32'(access_fault), 32'd0);
    check_mmio();
    @(negedge clock);
    reset = 1'b1;
    repeat (LAT + 2) @(posedge clock);
    #1;
    check("rst_idle_ready", 32'(memory_ready), 32'd0);
    access(32'h200, 2'd0, 1'b0, 32'h0);

    access(32'(RAM - 2), 2'd0, 1'b1, 32'h11);
    access(32'(RAM - 1), 2'd0, 1'b1, 32'h22);
    access(32'(RAM - 2), 2'd2, 1'b1, 32'hFFFFFFFF);
    access(32'(RAM - 1), 2'd0, 1'b0, 32'h0);
    access(32'(RAM - 2), 2'd1, 1'b0, 32'h0);
    access(32'h104, 2'd3, 1'b0, 32'h0);
    access(32'h104, 2'd3, 1'b1, 32'h0);
    access(32'h104, 2'd2, 1'b0, 32'h0);
    check_mmio();

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
